// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the write-back port arbiter: index/data widths, FSM states
// and the long-latency result FIFO entry.
package wb_port_arbiter_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO for long-latency results; wrap-around pointers carry an
// extra MSB so full and empty are distinguished without a separate count.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and buffered
// long-latency results. Optional same-cycle LU bypass: WB_ARB_BYPASS_EN.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_valid,
  input  logic [REG_W-1:0]  pipe_wb_rd,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              lu_issue_valid,
  input  logic [REG_W-1:0]  lu_issue_rd,
  input  logic              lu_done_valid,
  input  logic [REG_W-1:0]  lu_done_rd,
  input  logic [DATA_W-1:0] lu_done_data,
  output logic              lu_done_ready,
  input  logic [REG_W-1:0]  dec_rs1,
  input  logic [REG_W-1:0]  dec_rs2,
  input  logic [REG_W-1:0]  dec_rd,
  output logic              dec_hazard,
  output logic              wb_stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]      sb_q, sb_d;

  logic      fifo_full, fifo_empty, fifo_push;
  wb_entry_t fifo_head, push_entry;

  logic grant_pipe, grant_fifo, grant_byp, byp_cand;
  logic [REG_W-1:0]  win_rd;
  logic [DATA_W-1:0] win_data;
  logic              win_valid;

`ifdef WB_ARB_BYPASS_EN
  assign byp_cand = lu_done_valid;
`else
  assign byp_cand = 1'b0;
`endif

  assign lu_done_ready   = !fifo_full;
  assign push_entry.rd   = lu_done_rd;
  assign push_entry.data = lu_done_data;
  // rd=0 results are acknowledged but never occupy a slot.
  assign fifo_push = lu_done_valid && lu_done_ready &&
                     (lu_done_rd != '0) && !grant_byp;

  wb_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (grant_fifo),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    grant_pipe = 1'b0;
    grant_fifo = 1'b0;
    grant_byp  = 1'b0;
    wb_stall   = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    case (state_q)
      ST_FORCE: begin
        // Exactly one forced pop, then back to pipe priority.
        if (!fifo_empty) begin
          grant_fifo = 1'b1;
          wb_stall   = pipe_wb_valid;
        end else begin
          grant_pipe = pipe_wb_valid;
        end
        state_d = ST_NORMAL;
        cnt_d   = '0;
      end
      default: begin
        if (pipe_wb_valid)    grant_pipe = 1'b1;
        else if (!fifo_empty) grant_fifo = 1'b1;
        else                  grant_byp  = byp_cand;
        if (fifo_empty || grant_fifo) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) state_d = ST_FORCE;
        end
      end
    endcase
  end

  always_comb begin
    win_valid = grant_pipe || grant_fifo || grant_byp;
    win_rd    = '0;
    win_data  = '0;
    if (grant_pipe) begin
      win_rd   = pipe_wb_rd;
      win_data = pipe_wb_data;
    end else if (grant_fifo) begin
      win_rd   = fifo_head.rd;
      win_data = fifo_head.data;
    end else if (grant_byp) begin
      win_rd   = lu_done_rd;
      win_data = lu_done_data;
    end
  end

  // An x0 grant still consumes the slot but never reaches the register file.
  assign rf_we    = win_valid && (win_rd != '0);
  assign rf_waddr = rf_we ? win_rd   : '0;
  assign rf_wdata = rf_we ? win_data : '0;

  always_comb begin
    sb_d = sb_q;
    if (grant_fifo) sb_d[fifo_head.rd] = 1'b0;
    if (grant_byp)  sb_d[lu_done_rd]   = 1'b0;
    // Applied last so a same-cycle reissue keeps the register pending.
    if (lu_issue_valid) sb_d[lu_issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  assign dec_hazard = sb_q[dec_rs1] | sb_q[dec_rs2] | sb_q[dec_rd];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, STARVE_MAX=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        lu_issue_valid;
  logic [4:0]  lu_issue_rd;
  logic        lu_done_valid;
  logic [4:0]  lu_done_rd;
  logic [31:0] lu_done_data;
  logic        lu_done_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_hazard, wb_stall, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_wb_valid  (pipe_wb_valid),
    .pipe_wb_rd     (pipe_wb_rd),
    .pipe_wb_data   (pipe_wb_data),
    .lu_issue_valid (lu_issue_valid),
    .lu_issue_rd    (lu_issue_rd),
    .lu_done_valid  (lu_done_valid),
    .lu_done_rd     (lu_done_rd),
    .lu_done_data   (lu_done_data),
    .lu_done_ready  (lu_done_ready),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .dec_hazard     (dec_hazard),
    .wb_stall       (wb_stall),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'(we));
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_wb_valid = v; pipe_wb_rd = rd; pipe_wb_data = d;
  endtask

  task automatic done(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_done_valid = v; lu_done_rd = rd; lu_done_data = d;
  endtask

  initial begin
    rst = 1'b0;
    pipe(0, 0, 0); done(0, 0, 0);
    lu_issue_valid = 0; lu_issue_rd = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;

    // reset state
    #2;
    chk("rst.ready", 32'(lu_done_ready), 1);
    chk_wr("rst", 0, 0, 0);
    chk("rst.stall", 32'(wb_stall), 0);
    chk("rst.hazard", 32'(dec_hazard), 0);
    tick(); tick();
    rst = 1'b1;
    tick(); #2;
    chk("idle.ready", 32'(lu_done_ready), 1);
    chk_wr("idle", 0, 0, 0);

    // pipe-only write
    pipe(1, 5, 32'h1234); #2;
    chk_wr("pipe", 1, 5, 32'h1234);
    chk("pipe.stall", 32'(wb_stall), 0);
    tick(); pipe(0, 0, 0);

    // scoreboard: issue rd7, then complete it
    lu_issue_valid = 1; lu_issue_rd = 7; dec_rs1 = 7; #2;
    chk("sb.same_cycle", 32'(dec_hazard), 0);
    tick(); lu_issue_valid = 0; #2;
    chk("sb.set", 32'(dec_hazard), 1);
    tick(); done(1, 7, 32'hCAFE); #2;
`ifdef WB_ARB_BYPASS_EN
    chk_wr("lu.bypass", 1, 7, 32'hCAFE);
    tick(); done(0, 0, 0); #2;
    chk("sb.clear", 32'(dec_hazard), 0);
`else
    chk_wr("lu.push", 0, 0, 0);
    tick(); done(0, 0, 0); #2;
    chk_wr("lu.write", 1, 7, 32'hCAFE);
    chk("sb.before_clear", 32'(dec_hazard), 1);
    tick(); #2;
    chk("sb.clear", 32'(dec_hazard), 0);
    chk_wr("lu.after", 0, 0, 0);
`endif
    dec_rs1 = 0;

    // starvation: pipe busy, one FIFO entry rd3
    tick(); pipe(1, 1, 32'h11); done(1, 3, 32'h33); #2;
    chk_wr("starve.push", 1, 1, 32'h11);
    for (int i = 0; i < 4; i++) begin
      tick(); done(0, 0, 0); pipe(1, 5'(2 + i), 32'(i)); #2;
      chk_wr($sformatf("starve.deny%0d", i), 1, 5'(2 + i), 32'(i));
      chk($sformatf("starve.stall%0d", i), 32'(wb_stall), 0);
    end
    tick(); pipe(1, 6, 32'h66); #2;
    chk("force.stall", 32'(wb_stall), 1);
    chk_wr("force", 1, 3, 32'h33);
    tick(); #2;
    chk("resume.stall", 32'(wb_stall), 0);
    chk_wr("resume", 1, 6, 32'h66);

    // fill FIFO while pipe busy, then drain in order
    tick(); pipe(1, 9, 32'h99); done(1, 10, 32'hA0); #2;
    chk("fill.ready0", 32'(lu_done_ready), 1);
    tick(); done(1, 11, 32'hB0); #2;
    chk("fill.ready1", 32'(lu_done_ready), 1);
    tick(); done(1, 12, 32'hC0); #2;
    chk("fill.full", 32'(lu_done_ready), 0);
    chk_wr("fill.pipe", 1, 9, 32'h99);
    tick(); pipe(0, 0, 0); #2;
    chk("pop.ready_same", 32'(lu_done_ready), 0);
    chk_wr("drain0", 1, 10, 32'hA0);
    tick(); #2;
    chk("pop.ready_next", 32'(lu_done_ready), 1);
    chk_wr("drain1", 1, 11, 32'hB0);
    tick(); done(0, 0, 0); #2;
    chk_wr("drain2", 1, 12, 32'hC0);
    tick(); #2;
    chk_wr("drained", 0, 0, 0);

    // x0 handling
    done(1, 0, 32'hDEAD); lu_issue_valid = 1; lu_issue_rd = 0; #2;
    chk_wr("x0.done", 0, 0, 0);
    tick(); done(0, 0, 0); lu_issue_valid = 0; #2;
    chk_wr("x0.done_next", 0, 0, 0);
    chk("x0.hazard", 32'(dec_hazard), 0);
    pipe(1, 0, 32'hBEEF); #2;
    chk_wr("x0.pipe", 0, 0, 0);
    chk("x0.stall", 32'(wb_stall), 0);
    tick(); pipe(0, 0, 0);

    // same-cycle clear and reissue keeps the bit set
    lu_issue_valid = 1; lu_issue_rd = 4; dec_rs2 = 4;
    tick(); lu_issue_valid = 0; done(1, 4, 32'h44);
`ifndef WB_ARB_BYPASS_EN
    tick(); done(0, 0, 0);
`endif
    lu_issue_valid = 1; lu_issue_rd = 4; #2;
    chk_wr("reissue.write", 1, 4, 32'h44);
    tick(); done(0, 0, 0); lu_issue_valid = 0; #2;
    chk("reissue.hazard", 32'(dec_hazard), 1);
    dec_rs2 = 0;

    // asynchronous reset mid-operation
    pipe(1, 1, 32'h1); lu_issue_valid = 1; lu_issue_rd = 8; done(1, 8, 32'h88); dec_rd = 8;
    tick(); lu_issue_valid = 0; done(0, 0, 0); pipe(0, 0, 0); #2;
    chk("arst.pre_hazard", 32'(dec_hazard), 1);
    rst = 1'b0; #1;
    chk("arst.hazard", 32'(dec_hazard), 0);
    chk("arst.ready", 32'(lu_done_ready), 1);
    chk_wr("arst", 0, 0, 0);
    tick(); rst = 1'b1;
    tick(); #2;
    chk_wr("arst.discard", 0, 0, 0);
    chk("arst.hazard_after", 32'(dec_hazard), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
